// File: rtl/sub_32bit_serial_if.sv
// Bus bundle for the serial 32-bit subtractor: operand/start request from
// the master side and result/status/handshake back from the slave side.
interface sub_32bit_serial_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
  logic        NegativeFlag;
  logic        ZeroFlag;
  logic        OverflowFlag;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, NegativeFlag, ZeroFlag, OverflowFlag
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, NegativeFlag, ZeroFlag, OverflowFlag
  );
endinterface

// File: rtl/sub_32bit_serial.sv
// Multi-cycle 32-bit subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin, DIGIT_W bits per clock over 32/DIGIT_W cycles.
// Produces borrow-out plus Negative/Zero status flags.
// Optional macro SUB_OVERFLOW_FLAG_EN enables the signed-overflow flag;
// without it OverflowFlag is a constant 0.
module sub_32bit_serial #(
  parameter int DIGIT_W = 4
) (
  input logic             clk,
  input logic             reset,
  sub_32bit_serial_if.slave bus
);

  localparam int N     = 32 / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
        DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_width
    $fatal(1, "sub_32bit_serial: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [31:0]      work_a;
  logic [31:0]      work_b;
  logic [31:0]      work_res;
  logic             carry;

  logic             busy_r;
  logic             done_r;
  logic [31:0]      diff_r;
  logic             bout_r;
  logic             neg_r;
  logic             zero_r;
  logic             ovf_r;

  logic [DIGIT_W:0] digit_sum;
  logic [31:0]      res_next;

  // One digit of a + ~b + carry; the top bit is the carry into the next digit.
  always_comb begin
    digit_sum = {1'b0, work_a[DIGIT_W-1:0]} + {1'b0, ~work_b[DIGIT_W-1:0]}
              + {{DIGIT_W{1'b0}}, carry};
  end

  // New digits enter at the top so after N steps the result is in place.
  if (DIGIT_W == 32) begin : g_full
    assign res_next = digit_sum[31:0];
  end else begin : g_shift
    assign res_next = {digit_sum[DIGIT_W-1:0], work_res[31:DIGIT_W]};
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  logic sign_a;
  logic sign_b;

  // Operand sign bits are kept aside because the working copies are shifted away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sign_a <= bus.a[31];
      sign_b <= bus.b[31];
    end else if (state == RUN && count == LAST) begin
      ovf_r <= (sign_a != sign_b) && (res_next[31] != sign_a);
    end
  end
`else
  assign ovf_r = 1'b0;
`endif

  // Handshake FSM and digit-serial datapath; results load only on the done edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      work_a   <= '0;
      work_b   <= '0;
      work_res <= '0;
      carry    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
      neg_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work_a <= bus.a;
            work_b <= bus.b;
            carry  <= ~bus.bin;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          work_a   <= work_a >> DIGIT_W;
          work_b   <= work_b >> DIGIT_W;
          work_res <= res_next;
          carry    <= digit_sum[DIGIT_W];
          count    <= count + 1'b1;
          if (count == LAST) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            diff_r <= res_next;
            bout_r <= ~digit_sum[DIGIT_W];
            neg_r  <= res_next[31];
            zero_r <= (res_next == 32'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.diff         = diff_r;
  assign bus.bout         = bout_r;
  assign bus.NegativeFlag = neg_r;
  assign bus.ZeroFlag     = zero_r;
  assign bus.OverflowFlag = ovf_r;

endmodule

// File: tb/tb_sub_32bit_serial.sv
// Directed bench for sub_32bit_serial with DIGIT_W = 4, 1 and 32 instances.
// Expected overflow depends on SUB_OVERFLOW_FLAG_EN.
module tb_sub_32bit_serial;

  logic clk;
  logic reset;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        bin_in;
  logic [2:0]  start_v;

  int vectors;
  int miscompares;

`ifdef SUB_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        neg;
    logic        zero;
    logic        ovf;
  } out_t;

  out_t outs [3];

  sub_32bit_serial_if bus4 ();
  sub_32bit_serial_if bus1 ();
  sub_32bit_serial_if bus32 ();

  assign bus4.a  = a_in;  assign bus4.b  = b_in;  assign bus4.bin  = bin_in;  assign bus4.start  = start_v[0];
  assign bus1.a  = a_in;  assign bus1.b  = b_in;  assign bus1.bin  = bin_in;  assign bus1.start  = start_v[1];
  assign bus32.a = a_in;  assign bus32.b = b_in;  assign bus32.bin = bin_in;  assign bus32.start = start_v[2];

  assign outs[0] = {bus4.busy, bus4.done, bus4.diff, bus4.bout, bus4.NegativeFlag, bus4.ZeroFlag, bus4.OverflowFlag};
  assign outs[1] = {bus1.busy, bus1.done, bus1.diff, bus1.bout, bus1.NegativeFlag, bus1.ZeroFlag, bus1.OverflowFlag};
  assign outs[2] = {bus32.busy, bus32.done, bus32.diff, bus32.bout, bus32.NegativeFlag, bus32.ZeroFlag, bus32.OverflowFlag};

  sub_32bit_serial #(.DIGIT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
  sub_32bit_serial #(.DIGIT_W(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
  sub_32bit_serial #(.DIGIT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves start high across one posedge, returns at the
  // following negedge with operands scrambled to show they are not re-sampled.
  task automatic apply_stimulus(input int sel, input logic [31:0] a, input logic [31:0] b, input logic bin);
    a_in = a;
    b_in = b;
    bin_in = bin;
    start_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_in = 32'hDEAD_BEEF;
    b_in = 32'h0BAD_F00D;
    bin_in = ~bin;
  endtask

  // Waits (bounded) for done, starting from an already-elapsed cycle count.
  task automatic wait_done(input int sel, input int cycles0, input int lat, input string tag);
    int cycles;
    cycles = cycles0;
    while (cycles < lat + 20) begin
      @(negedge clk);
      cycles++;
      if (outs[sel].done) break;
    end
    check({tag, "_latency"}, cycles, lat);
  endtask

  task automatic check_output(input int sel, input string tag, input logic [31:0] diff,
                              input logic bout, input logic neg, input logic zero, input logic ovf);
    check({tag, "_diff"}, outs[sel].diff, diff);
    check({tag, "_bout"}, {31'd0, outs[sel].bout}, {31'd0, bout});
    check({tag, "_neg"},  {31'd0, outs[sel].neg},  {31'd0, neg});
    check({tag, "_zero"}, {31'd0, outs[sel].zero}, {31'd0, zero});
    check({tag, "_ovf"},  {31'd0, outs[sel].ovf},  {31'd0, ovf});
    check({tag, "_busy"}, {31'd0, outs[sel].busy}, 32'd0);
  endtask

  // Directed sequence covering arithmetic cases, handshake corners and widths.
  initial begin
    int seen_done;
    vectors = 0;
    miscompares = 0;
    a_in = '0;
    b_in = '0;
    bin_in = 1'b0;
    start_v = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_output(0, "reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_done", {31'd0, outs[0].done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] positive result");
    apply_stimulus(0, 32'd5, 32'd3, 1'b0);
    wait_done(0, 0, 8, "pos");
    check_output(0, "pos", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pos_done_pulse", {31'd0, outs[0].done}, 32'd0);

    $display("[TB] negative result with ignored start");
    apply_stimulus(0, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("neg_busy_mid", {31'd0, outs[0].busy}, 32'd1);
    check("neg_hold_mid", outs[0].diff, 32'h0000_0002);
    a_in = 32'd7;
    b_in = 32'd7;
    bin_in = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 3, 8, "neg");
    check_output(0, "neg", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("neg_no_restart", {31'd0, outs[0].busy}, 32'd0);

    $display("[TB] zero result");
    apply_stimulus(0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    wait_done(0, 0, 8, "zero");
    check_output(0, "zero", 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] borrow-in");
    apply_stimulus(0, 32'd0, 32'd0, 1'b1);
    wait_done(0, 0, 8, "bin");
    check_output(0, "bin", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] signed overflow");
    apply_stimulus(0, 32'h8000_0000, 32'd1, 1'b0);
    wait_done(0, 0, 8, "ovf");
    check_output(0, "ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, OVF_EXP);
    @(negedge clk);

    $display("[TB] back-to-back");
    apply_stimulus(0, 32'd10, 32'd4, 1'b0);
    wait_done(0, 0, 8, "b2b_first");
    check_output(0, "b2b_first", 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 32'd100, 32'd1, 1'b0);
    wait_done(0, 0, 8, "b2b_second");
    check_output(0, "b2b_second", 32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] reset mid-run");
    apply_stimulus(0, 32'd9, 32'd2, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #2;
    check_output(0, "midreset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midreset_done", {31'd0, outs[0].done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (outs[0].done) seen_done++;
    end
    check("midreset_no_done", seen_done, 32'd0);

    $display("[TB] DIGIT_W=1");
    apply_stimulus(1, 32'd5, 32'd3, 1'b0);
    wait_done(1, 0, 32, "w1");
    check_output(1, "w1", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] DIGIT_W=32");
    apply_stimulus(2, 32'd5, 32'd3, 1'b0);
    wait_done(2, 0, 1, "w32");
    check_output(2, "w32", 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("w32_done_pulse", {31'd0, outs[2].done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
